// File: rtl/syn_reg_arbiter.sv
// syn_reg_arbiter: round-robin arbiter and load sequencer for one shared
// register written by NREQ requesters over a 4-phase REQ/ACK handshake.
// The winner holds GNT for HOLD cycles. Its data is then loaded into Q, and
// ACK is held until that requester drops REQ.
module syn_reg_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic                  CLK,
  input  logic                  R_B,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] D,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      Q_B,
  output logic                  BUSY
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic [WIDTH-1:0]   d_arr [NREQ];
  logic [IW-1:0]      cand;
  logic [IW-1:0]      pick_idx_c;
  logic               pick_vld_c;

  // Split the flat data bus into one slice per requester
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      d_arr[i] = D[i*WIDTH +: WIDTH];
    end
  end

  // Circular search for the first request after the last-served requester
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(last_q) + 32'd1 + k) % NREQ);
      if (!pick_vld_c && REQ[cand]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          idx_d             = pick_idx_c;
          gnt_d             = '0;
          gnt_d[pick_idx_c] = 1'b1;
          cnt_d             = '0;
          state_d           = GRANT;
        end
      end

      GRANT: begin
        // An abort takes priority over reaching the final count
        if (!REQ[idx_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          q_d          = d_arr[idx_q];
          ack_d        = '0;
          ack_d[idx_q] = 1'b1;
          gnt_d        = '0;
          last_d       = idx_q;
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE: begin
        if (!REQ[idx_q]) begin
          ack_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any pending load
  always_ff @(posedge CLK or negedge R_B) begin
    if (!R_B) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IDX_MAX;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign Q    = q_q;
  assign Q_B  = ~q_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_syn_reg_arbiter.sv
// Directed testbench for syn_reg_arbiter with default parameters.
`timescale 1ns/100ps
module tb_syn_reg_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned HOLD  = 2;

  logic                  clk;
  logic                  r_b;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] d;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      q_b;
  logic                  busy;

  int n_run;
  int n_fail;

  syn_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .CLK  (clk),
    .R_B  (r_b),
    .REQ  (req),
    .D    (d),
    .GNT  (gnt),
    .ACK  (ack),
    .Q    (q),
    .Q_B  (q_b),
    .BUSY (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          order [6];
    logic [7:0]  dv [4];
    int          g;
    int          pend;

    n_run  = 0;
    n_fail = 0;
    order  = '{0, 1, 2, 3, 0, 1};
    dv     = '{8'h11, 8'h3C, 8'h33, 8'h44};
    pend   = 0;

    r_b = 1'b0;
    req = '0;
    d   = '0;

    // Reset values
    #2;
    check("rst_q",    32'(q),    32'h00);
    check("rst_q_b",  32'(q_b),  32'hFF);
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_ack",  32'(ack),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #10;
    r_b = 1'b1;
    tick();

    // Reset during GRANT with D1=3C pending
    d   = {dv[3], dv[2], dv[1], dv[0]};
    req = 4'b0010;
    tick();
    check("rg_gnt",  32'(gnt),  32'h2);
    check("rg_busy", 32'(busy), 32'h1);
    #1.5;
    r_b = 1'b0;
    #1;
    check("arst_q",    32'(q),    32'h00);
    check("arst_q_b",  32'(q_b),  32'hFF);
    check("arst_gnt",  32'(gnt),  32'h0);
    check("arst_ack",  32'(ack),  32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    tick();
    check("arst_hold_q", 32'(q), 32'h00);
    #2;
    r_b = 1'b1;
    req = 4'b1111;

    // Round-robin: each requester re-raises one cycle after its ACK falls
    for (int i = 0; i < 6; i++) begin
      g = order[i];
      tick();
      check("rr_gnt", 32'(gnt), 32'd1 << g);
      if (i > 0) req[pend] = 1'b1;
      tick();
      tick();
      check("rr_q",     32'(q),   32'(dv[g]));
      check("rr_ack",   32'(ack), 32'd1 << g);
      check("rr_gnt_0", 32'(gnt), 32'h0);
      req[g] = 1'b0;
      tick();
      check("rr_ack_0", 32'(ack),  32'h0);
      check("rr_idle",  32'(busy), 32'h0);
      pend = g;
    end
    req = '0;

    // Pointer priority: last served is 1, so 3 beats 1
    req = 4'b1010;
    tick();
    check("pp_gnt_a", 32'(gnt), 32'h8);
    tick();
    tick();
    check("pp_q_a",   32'(q),   32'h44);
    check("pp_ack_a", 32'(ack), 32'h8);
    req = 4'b0010;
    tick();
    check("pp_ack_a0", 32'(ack), 32'h0);
    tick();
    check("pp_gnt_b", 32'(gnt), 32'h2);
    tick();
    tick();
    check("pp_q_b",   32'(q),   32'h3C);
    check("pp_ack_b", 32'(ack), 32'h2);
    req = '0;
    tick();
    check("pp_ack_b0", 32'(ack),  32'h0);
    check("pp_idle",   32'(busy), 32'h0);

    // Abort one edge after grant
    d[23:16] = 8'h77;
    req = 4'b0100;
    tick();
    check("ab_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("ab_gnt_0", 32'(gnt),  32'h0);
    check("ab_ack",   32'(ack),  32'h0);
    check("ab_busy",  32'(busy), 32'h0);
    check("ab_q",     32'(q),    32'h3C);
    tick();
    check("ab_q_late",   32'(q),   32'h3C);
    check("ab_ack_late", 32'(ack), 32'h0);

    // LAST untouched by the abort: search resumes after 1, so 2 wins
    req = 4'b1111;
    tick();
    check("ab_last_gnt", 32'(gnt), 32'h4);
    tick();
    tick();
    check("ab_last_q", 32'(q), 32'h77);
    req = '0;
    tick();

    // Abort coinciding with the final count: no load
    req = 4'b0001;
    tick();
    check("abf_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    check("abf_gnt_0", 32'(gnt),  32'h0);
    check("abf_ack",   32'(ack),  32'h0);
    check("abf_q",     32'(q),    32'h77);
    check("abf_busy",  32'(busy), 32'h0);

    // Single write of A5 from requester 0
    d[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    check("sw_gnt", 32'(gnt), 32'h1);
    tick();
    check("sw_ack_early", 32'(ack), 32'h0);
    tick();
    check("sw_q",     32'(q),   32'hA5);
    check("sw_q_b",   32'(q_b), 32'h5A);
    check("sw_ack",   32'(ack), 32'h1);
    check("sw_gnt_0", 32'(gnt), 32'h0);
    req = '0;
    tick();
    check("sw_ack_0", 32'(ack),  32'h0);
    check("sw_busy",  32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_reg_arbiter.md
# syn_reg_arbiter

Round-robin arbiter and load sequencer for one shared WIDTH-bit register, built from resettable D flip-flops, that NREQ requesters write through a 4-phase REQ/ACK handshake. The block picks one requester, holds its grant for a fixed settle window, loads that requester's data into the register, and acknowledges. It drives Q and Q_B directly, so the register it serves is internal to this block. It sits between local bus-side masters and any logic that reads the shared register.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- WIDTH, 8: width of the shared register.
- HOLD, 2: grant cycles before the load; legal range 1..15; 0 is illegal.
- CLK  in  1  clock; all state changes on the rising edge.
- R_B  in  1  reset; asynchronous, active-low.
- REQ  in  NREQ  per-requester write request; level-held 4-phase.
- D  in  NREQ*WIDTH  flat data; requester i uses D[i*WIDTH +: WIDTH].
- GNT  out  NREQ  one-hot grant; all zero when no grant is active.
- ACK  out  NREQ  one-hot acknowledge.
- Q  out  WIDTH  shared register value.
- Q_B  out  WIDTH  bitwise complement of Q.
- BUSY  out  1  high in every state except IDLE.

## Operation
- **Reset (R_B=0, no clock edge needed).** State=IDLE; GNT=0; ACK=0; Q=0; Q_B=all ones; BUSY=0; count=0; last-served pointer LAST=NREQ-1, so requester 0 wins first.
- **States.** IDLE, GRANT, RELEASE. The state is held in registers.
- **IDLE.**
  - If REQ≠0, pick the first set REQ bit, searching circularly from LAST+1.
  - Set GNT to that one-hot index g, set count=0, go to GRANT.
  - If REQ=0, stay in IDLE.
- **GRANT.**
  - If REQ[g]=0 at an edge (abort): GNT=0, go to IDLE. Q, ACK and LAST are unchanged.
  - Else if count==HOLD-1: Q<=D slice g; ACK[g]=1; GNT=0; LAST<=g; go to RELEASE.
  - Else count<=count+1.
- **RELEASE.**
  - ACK[g] is held high.
  - When REQ[g]=0 at an edge: ACK=0, go to IDLE.
  - Other requesters' REQ are ignored until IDLE.
- **Register rules.**
  - Q_B is always exactly ~Q, including during and after reset.
  - Q changes only on a load or on reset.
- **Requester rules.**
  - A requester must hold D stable from raising REQ until it sees ACK.
  - Any other REQ changes are tolerated. Only REQ[g] is examined while BUSY=1.
- **Counter.** 4 bits wide, sufficient for the maximum HOLD.

## Timing
- **Load latency.** Edge e0 samples REQ in IDLE and GNT rises after e0. Q loads and ACK rises after edge e0+HOLD, in the same cycle GNT falls.
- **Release.** ACK falls after the first edge that samples REQ[g]=0 in RELEASE.
- **Back-to-back.** The earliest next grant is the edge after returning to IDLE: minimum HOLD+2 edges per transaction, with the requester dropping REQ immediately.
- **Simultaneous requests.** Resolved by the circular priority alone, with no fixed priority.
- **Abort versus final count.** If REQ[g] drops at the same edge that count reaches HOLD-1, the abort wins and no load occurs.
- **Reset mid-operation.** Asserting R_B in any state clears all outputs immediately and discards the pending load. After R_B deasserts, the first edge that samples a request behaves as IDLE with LAST=NREQ-1.
- **Outputs.** GNT, ACK, Q and BUSY are registered, with no combinational REQ-to-output paths. Q_B is a combinational inversion of registered Q.

## Test plan
Defaults apply unless stated: NREQ=4, WIDTH=8, HOLD=2.
- **Async reset.** Drop R_B at t=CLK period/4, mid-operation, with no edge. Required: Q=00, Q_B=FF, GNT=0000, ACK=0000, BUSY=0 before the next edge.
- **Single write.** REQ=0001, D0=A5. Required: GNT=0001 after e0; Q=A5, Q_B=5A, ACK=0001, GNT=0000 after e0+2. Then drop REQ. Required: ACK=0000 and BUSY=0 one edge later.
- **Round-robin fairness.** All four requesters re-raise REQ one cycle after their ACK falls. Required: grant order 0,1,2,3,0,1; Q sequence matches D0..D3.
- **Pointer-based priority.** After requester 1 is served, REQ=1010 rises together. Required: GNT=1000 first, then 0010.
- **Abort.** REQ[2] drops one edge after GNT=0100. Required: no ACK, Q unchanged, IDLE on the next edge, LAST unchanged.
- **Reset during GRANT.** Pulse R_B low while GNT=0010, with D1=3C pending. Required: Q stays 00 and is never 3C. After release with REQ=1111, the first grant is 0001.
